// File: rtl/tdc_pkg.sv
// Shared types for the tdc readout path: FSM states, capture quality flags, code width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SAMPLE,
    ST_CLEAR,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic bubble;
    logic ovf;
    logic unf;
  } tdc_flags_t;

  // One extra bit so a fully set line (code == n_delay) is representable.
  function automatic int cnt_width(input int n_delay);
    return $clog2(n_delay) + 1;
  endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary encoder for one delay-line capture, with bubble/overflow/underflow flags.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module tdc_therm_enc
  import tdc_pkg::*;
#(
  parameter int N_DELAY = 256,
  parameter int CNT_W   = cnt_width(N_DELAY)
) (
  input  logic [N_DELAY-1:0] therm,
  output logic [CNT_W-1:0]   code,
  output tdc_flags_t         flags
);

  // Priority search upward from stage 0: the first 0 fixes the code, any 1 above it is a bubble.
  always_comb begin
    logic found;
    found = 1'b0;
    code  = CNT_W'(N_DELAY);
    flags = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      if (!found && !therm[i]) begin
        found = 1'b1;
        code  = CNT_W'(i);
      end else if (found && therm[i]) begin
        flags.bubble = 1'b1;
      end
    end
    flags.ovf = &therm;
    flags.unf = ~therm[0];
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: fires the TDC, captures and encodes 2^AVG_LOG2 results, presents the average.
// Latency: trigger at edge k -> o_valid from cycle k+1+2^AVG_LOG2*(2+CLR_CYC).
// Backpressure: result held in DONE until i_ready; triggers outside IDLE are dropped, not queued.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int N_DELAY  = 256,
  parameter int CNT_W    = cnt_width(N_DELAY),
  parameter int AVG_LOG2 = 2,
  parameter int CLR_CYC  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_trig,
  output logic               o_tdc_start,
  input  logic [N_DELAY-1:0] i_tdc_result,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [CNT_W-1:0]   o_code,
  output logic               o_bubble,
  output logic               o_ovf,
  output logic               o_unf
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int MC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CC_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [MC_W-1:0] MEAS_LAST = MC_W'((1 << AVG_LOG2) - 1);
  localparam logic [CC_W-1:0] CLR_LAST  = CC_W'(CLR_CYC - 1);

  state_t             state;
  logic [N_DELAY-1:0] cap;
  logic [MC_W-1:0]    meas_cnt;
  logic [CC_W-1:0]    clr_cnt;
  logic [ACC_W-1:0]   acc;
  tdc_flags_t         flags_acc;

  logic [CNT_W-1:0]   enc_code;
  tdc_flags_t         enc_flags;
  logic [ACC_W-1:0]   acc_sum;
  tdc_flags_t         flags_sum;

  tdc_therm_enc #(
    .N_DELAY (N_DELAY),
    .CNT_W   (CNT_W)
  ) u_enc (
    .therm (cap),
    .code  (enc_code),
    .flags (enc_flags)
  );

  // Fold the current capture in on the first CLEAR cycle only; later CLEAR cycles pass through.
  // Computed ahead of the register so a CLR_CYC of 1 can still fold and finish on the same edge.
  always_comb begin
    acc_sum   = acc;
    flags_sum = flags_acc;
    if (clr_cnt == '0) begin
      acc_sum   = acc + ACC_W'(enc_code);
      flags_sum = tdc_flags_t'(flags_acc | enc_flags);
    end
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cap         <= '0;
      meas_cnt    <= '0;
      clr_cnt     <= '0;
      acc         <= '0;
      flags_acc   <= '0;
      o_tdc_start <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_code      <= '0;
      o_bubble    <= 1'b0;
      o_ovf       <= 1'b0;
      o_unf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_trig) begin
            state       <= ST_LAUNCH;
            meas_cnt    <= '0;
            acc         <= '0;
            flags_acc   <= '0;
            o_code      <= '0;
            o_bubble    <= 1'b0;
            o_ovf       <= 1'b0;
            o_unf       <= 1'b0;
            o_tdc_start <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          cap         <= i_tdc_result;
          clr_cnt     <= '0;
          o_tdc_start <= 1'b0;
          state       <= ST_CLEAR;
        end
        ST_CLEAR: begin
          acc       <= acc_sum;
          flags_acc <= flags_sum;
          if (clr_cnt == CLR_LAST) begin
            if (meas_cnt == MEAS_LAST) begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              o_code   <= CNT_W'(acc_sum >> AVG_LOG2);
              o_bubble <= flags_sum.bubble;
              o_ovf    <= flags_sum.ovf;
              o_unf    <= flags_sum.unf;
            end else begin
              meas_cnt    <= meas_cnt + MC_W'(1);
              o_tdc_start <= 1'b1;
              state       <= ST_LAUNCH;
            end
          end else begin
            clr_cnt <= clr_cnt + CC_W'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_tdc_start <= 1'b0;
          o_busy      <= 1'b0;
          o_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule
